// File: rtl/pc_ctrl_if.sv
// Instruction-fetch / PC-select bundle between instruction memory, flags,
// register file index and the pc block.
interface pc_ctrl_if;
  logic [15:0] ins_in;
  logic        ins_valid_in;
  logic        n_in;
  logic        z_in;
  logic        fetch_req_out;
  logic [1:0]  ps_out;
  logic [2:0]  ra_sel_out;
  logic [15:0] ir_out;
  logic        halt_out;
  logic        err_out;

  // master: the sequencer; slave: memory / ALU / pc side
  modport master (
    input  ins_in, ins_valid_in, n_in, z_in,
    output fetch_req_out, ps_out, ra_sel_out, ir_out, halt_out, err_out
  );
  modport slave (
    output ins_in, ins_valid_in, n_in, z_in,
    input  fetch_req_out, ps_out, ra_sel_out, ir_out, halt_out, err_out
  );
endinterface

// File: rtl/pc_ctrl.sv
// Fetch/decode/execute sequencer producing one registered PC-select pulse
// per instruction, with a sticky fetch-timeout halt.
module pc_ctrl #(
  parameter logic [3:0]  OPC_BR    = 4'hC,
  parameter logic [3:0]  OPC_JR    = 4'hD,
  parameter logic [3:0]  OPC_HLT   = 4'hF,
  parameter int unsigned FETCH_TMO = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  pc_ctrl_if.master   bus
);
  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BR   = 2'b10;
  localparam logic [1:0] PS_LD   = 2'b11;
  localparam logic [7:0] CNT_LAST = 8'(FETCH_TMO - 1);

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [15:0] ir;
  logic [1:0]  ps;
  logic [2:0]  ra_sel;
  logic        fetch_req, halt, err;

  // cond bits ir[11:9] = n,z,p; an all-zero cond never branches
  function automatic logic [1:0] ps_decode(input logic [15:0] i, input logic n, input logic z);
    logic taken;
    taken = (i[11] & n) | (i[10] & z) | (i[9] & ~n & ~z);
    if (i[15:12] == OPC_BR)       ps_decode = taken ? PS_BR : PS_INC;
    else if (i[15:12] == OPC_JR)  ps_decode = PS_LD;
    else if (i[15:12] == OPC_HLT) ps_decode = PS_HOLD;
    else                          ps_decode = PS_INC;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      cnt       <= '0;
      ir        <= '0;
      ps        <= PS_HOLD;
      ra_sel    <= '0;
      fetch_req <= 1'b1;
      halt      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (bus.ins_valid_in) begin
            ir        <= bus.ins_in;
            ra_sel    <= bus.ins_in[5:3];
            cnt       <= '0;
            fetch_req <= 1'b0;
            state     <= S_DECODE;
          end else if (cnt == CNT_LAST) begin
            err       <= 1'b1;
            halt      <= 1'b1;
            fetch_req <= 1'b0;
            state     <= S_HALT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DECODE: begin
          ps    <= ps_decode(ir, bus.n_in, bus.z_in);
          state <= S_EXEC;
        end
        S_EXEC: begin
          // pc consumes ps on this edge; drop it so it is a single-cycle pulse
          ps <= PS_HOLD;
          if (ir[15:12] == OPC_HLT) begin
            halt  <= 1'b1;
            state <= S_HALT;
          end else begin
            fetch_req <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_HALT:  ;
        default: state <= S_FETCH;
      endcase
    end
  end

  assign bus.fetch_req_out = fetch_req;
  assign bus.ps_out        = ps;
  assign bus.ra_sel_out    = ra_sel;
  assign bus.ir_out        = ir;
  assign bus.halt_out      = halt;
  assign bus.err_out       = err;
endmodule
